pipe_fde_regs: RTL and testbench

- Pipeline register bank for the PC, IF/ID and ID/EX boundaries of the 5-stage MIPS core.
- Consumes the hazard unit's stallF, stallD and flushE outputs, plus the decode-stage branch-taken signal pcsrcD.
- Inserts bubbles and holds instructions as directed.
- Keeps saturating stall, flush and issue counters for performance debug.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/pipe_fde_regs_sat_counter.sv | 28 ++
 rtl/pipe_fde_regs.sv | 152 +++++++++++++++
 tb/tb_pipe_fde_regs.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core pipeline.
//   NOP_INSTR        : all-zero instruction (sll $0,$0,0) used for squashed slots.
//   CTRL_BUNDLE_W    : width of the packed decode control bundle.
//   ctrlBundleT      : layout of that bundle. All-zero means no regwrite,
//                      no memwrite and no branch, so a zeroed bundle is a
//                      safe bubble.
//   RESET_PC_DEFAULT : fetch address after reset.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          CTRL_BUNDLE_W    = 10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
    logic       branch;
    logic       branchne;
  } ctrlBundleT;

  localparam ctrlBundleT CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_fde_regs_sat_counter.sv
// sat_counter: CNT_W-bit up counter that sticks at its all-ones value.
//   clk, reset_n : clock, asynchronous active-low reset (clears count).
//   inc          : add one this cycle (ignored once saturated).
//   clr          : synchronous clear; wins over inc.
//   count        : current value.
module sat_counter
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_fde_regs.sv
// pipe_fde_regs: PC, IF/ID and ID/EX pipeline registers of the MIPS core,
// plus saturating stall / flush / issue performance counters.
//   Hazard controls : stallF (hold PC), stallD (hold IF/ID), flushE (bubble
//                     ID/EX), pcsrcD (taken branch in D, squashes IF/ID).
//   F inputs        : pcnextF, instrF, pcplus4F.
//   D inputs        : ctrlD, rd1D, rd2D, rsD, rtD, rdD, signimmD.
//   Outputs         : pcF; instrD, pcplus4D, validD; ctrlE, rd1E, rd2E, rsE,
//                     rtE, rdE, signimmE, validE; stall_cnt, flush_cnt,
//                     issue_cnt. All outputs come straight from flops.
//   cnt_clr         : synchronous clear of the three counters.
//   reset_n         : asynchronous active-low reset of every register.
module pipe_fde_regs
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int          CTRL_W   = CTRL_BUNDLE_W,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushE,
  input  logic              pcsrcD,
  input  logic [WIDTH-1:0]  pcnextF,
  input  logic [31:0]       instrF,
  input  logic [WIDTH-1:0]  pcplus4F,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [WIDTH-1:0]  rd1D,
  input  logic [WIDTH-1:0]  rd2D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [WIDTH-1:0]  signimmD,
  input  logic              cnt_clr,
  output logic [WIDTH-1:0]  pcF,
  output logic [31:0]       instrD,
  output logic [WIDTH-1:0]  pcplus4D,
  output logic              validD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [WIDTH-1:0]  rd1E,
  output logic [WIDTH-1:0]  rd2E,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [WIDTH-1:0]  signimmE,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  issue_cnt
);

  logic flushInc;
  logic issueInc;

  // ---- PC register (F) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcF <= RESET_PC;
    end else if (!stallF) begin
      pcF <= pcnextF;
    end
  end

  // ---- IF/ID boundary ----
  // A stall outranks a squash: the hazard unit keeps pcsrcD up until the
  // stall drops, and the squash lands on that first free cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instrD   <= NOP_INSTR;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (pcsrcD) begin
      instrD   <= NOP_INSTR;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else begin
      instrD   <= instrF;
      pcplus4D <= pcplus4F;
      validD   <= 1'b1;
    end
  end

  // ---- ID/EX boundary ----
  // Loads every cycle. On a load-use hazard flushE and stallD arrive together:
  // E takes a bubble while the IF/ID register above keeps its instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrlE    <= '0;
      rd1E     <= '0;
      rd2E     <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
      signimmE <= '0;
      validE   <= 1'b0;
    end else if (flushE) begin
      ctrlE    <= CTRL_W'(CTRL_BUBBLE);
      rd1E     <= '0;
      rd2E     <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
      signimmE <= '0;
      validE   <= 1'b0;
    end else begin
      ctrlE    <= ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      rsE      <= rsD;
      rtE      <= rtD;
      rdE      <= rdD;
      signimmE <= signimmD;
      validE   <= validD;
    end
  end

  // ---- Performance counters ----
  // A squash hidden behind a stall is not yet a flush, hence the ~stallD term.
  assign flushInc = flushE | (pcsrcD & ~stallD);
  assign issueInc = ~flushE & validD;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stallD),
    .clr     (cnt_clr),
    .count   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flushInc),
    .clr     (cnt_clr),
    .count   (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uIssueCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (issueInc),
    .clr     (cnt_clr),
    .count   (issue_cnt)
  );

endmodule

// File: tb/tb_pipe_fde_regs.sv
// Directed bench for pipe_fde_regs (CNT_W = 4 build so saturation is reachable).
// Each step drives one cycle of inputs and queues the hand-computed register
// state expected after the following clock edge; a monitor pops and compares.
module tb_pipe_fde_regs;

  localparam int W  = 32;
  localparam int CW = 10;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stallF, stallD, flushE, pcsrcD, cnt_clr;
  logic [W-1:0]  pcnextF, pcplus4F, rd1D, rd2D, signimmD;
  logic [31:0]   instrF;
  logic [CW-1:0] ctrlD;
  logic [4:0]    rsD, rtD, rdD;
  logic [W-1:0]  pcF, pcplus4D, rd1E, rd2E, signimmE;
  logic [31:0]   instrD;
  logic          validD, validE;
  logic [CW-1:0] ctrlE;
  logic [4:0]    rsE, rtE, rdE;
  logic [NW-1:0] stall_cnt, flush_cnt, issue_cnt;

  pipe_fde_regs #(.WIDTH(W), .RESET_PC(32'h0), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset_n(reset_n), .stallF(stallF), .stallD(stallD),
    .flushE(flushE), .pcsrcD(pcsrcD), .pcnextF(pcnextF), .instrF(instrF),
    .pcplus4F(pcplus4F), .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .signimmD(signimmD), .cnt_clr(cnt_clr),
    .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
    .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E), .rsE(rsE), .rtE(rtE), .rdE(rdE),
    .signimmE(signimmE), .validE(validE), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // D-stage fields are all derived from one tag word; every derivation maps
  // 0 to 0, so a tag of 0 also describes an ID/EX bubble.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        vD;
    logic [31:0] tag;
    logic        vE;
    int          s, f, i;
  } expT;

  expT  expQ[$];
  event chkEv;
  int   nCmp = 0;
  int   nBad = 0;

  localparam logic [31:0] I0 = 32'h8C01_0000, I1 = 32'h0022_1820,
                          I2 = 32'hAC03_0004, I3 = 32'h0064_2020,
                          IB = 32'h2008_0005, I5 = 32'h0109_5020,
                          I6 = 32'h1234_5678, I7 = 32'h2009_0007,
                          I8 = 32'h0128_5822, I9 = 32'h3C0A_BEEF;
  localparam logic [31:0] T1 = 32'h1111_2222, T2 = 32'h3333_4444,
                          T3 = 32'h5555_6666, T4 = 32'h0777_0888,
                          T6 = 32'h0ABC_0DEF, T7 = 32'h0246_0135,
                          T8 = 32'h7654_3210, T9 = 32'h0F1E_2D3C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares after each rising edge, or right after an
  // asynchronous-reset check is queued.
  always begin
    expT e;
    @(posedge clk or chkEv);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("pcF",       pcF,                    e.pc);
      chk("instrD",    instrD,                 e.instr);
      chk("pcplus4D",  pcplus4D,               rotl(e.instr, 4));
      chk("validD",    32'(validD),            32'(e.vD));
      chk("ctrlE",     32'(ctrlE),             32'(e.tag[9:0]));
      chk("rd1E",      rd1E,                   e.tag);
      chk("rd2E",      rd2E,                   rotl(e.tag, 8));
      chk("signimmE",  signimmE,               rotl(e.tag, 16));
      chk("rsE",       32'(rsE),               32'(e.tag[4:0]));
      chk("rtE",       32'(rtE),               32'(e.tag[9:5]));
      chk("rdE",       32'(rdE),               32'(e.tag[14:10]));
      chk("validE",    32'(validE),            32'(e.vE));
      chk("stall_cnt", 32'(stall_cnt),         32'(e.s));
      chk("flush_cnt", 32'(flush_cnt),         32'(e.f));
      chk("issue_cnt", 32'(issue_cnt),         32'(e.i));
    end
  end

  task automatic drive(input logic stF, stD, flE, pcs, clr,
                       input logic [31:0] pcn, ins, tag);
    stallF   = stF;  stallD = stD;  flushE = flE;  pcsrcD = pcs;  cnt_clr = clr;
    pcnextF  = pcn;
    instrF   = ins;
    pcplus4F = rotl(ins, 4);
    ctrlD    = tag[9:0];
    rd1D     = tag;
    rd2D     = rotl(tag, 8);
    signimmD = rotl(tag, 16);
    rsD      = tag[4:0];
    rtD      = tag[9:5];
    rdD      = tag[14:10];
  endtask

  task automatic step(input logic stF, stD, flE, pcs, clr,
                      input logic [31:0] pcn, ins, tag,
                      input logic [31:0] ePc, eInstr, input logic eVD,
                      input logic [31:0] eTag, input logic eVE,
                      input int eS, eF, eI);
    expT e;
    drive(stF, stD, flE, pcs, clr, pcn, ins, tag);
    e = '{pc: ePc, instr: eInstr, vD: eVD, tag: eTag, vE: eVE, s: eS, f: eF, i: eI};
    expQ.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic expectReset();
    expT e;
    e = '{pc: 32'h0, instr: 32'h0, vD: 1'b0, tag: 32'h0, vE: 1'b0, s: 0, f: 0, i: 0};
    expQ.push_back(e);
    ->chkEv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    expectReset();
    #2;
    reset_n = 1'b1;

    // Free-running fetch: pcF 0 -> 4 -> 8 -> 12.
    //   stF stD flE pcs clr  pcnextF  instrF  tag |  pcF  instrD vD  tagE vE  s  f  i
    step(0, 0, 0, 0, 0, 32'h4,   I0, 32'h0, 32'h4,   I0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h8,   I1, T1,    32'h8,   I1, 1, T1,    1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 32'hC,   I2, T2,    32'hC,   I2, 1, T2,    1, 0, 0, 2);

    // Load-use: PC and IF/ID hold, E bubbles; held instruction enters E next.
    step(1, 1, 1, 0, 0, 32'h10,  I3, T3,    32'hC,   I2, 1, 32'h0, 0, 1, 1, 2);
    step(0, 0, 0, 0, 0, 32'h10,  I3, T3,    32'h10,  I3, 1, T3,    1, 1, 1, 3);

    // Taken branch squashes the fetched instruction.
    step(0, 0, 0, 1, 0, 32'h100, IB, T4,    32'h100, 32'h0, 0, T4, 1, 1, 2, 4);

    // Branch held behind a stall, then released with pcsrcD still high.
    step(0, 0, 0, 0, 0, 32'h104, I5, 32'h0, 32'h104, I5, 1, 32'h0, 0, 1, 2, 4);
    step(1, 1, 0, 1, 0, 32'h108, I6, T6,    32'h104, I5, 1, T6,    1, 2, 2, 5);
    step(0, 0, 0, 1, 0, 32'h200, I6, T7,    32'h200, 32'h0, 0, T7, 1, 2, 3, 6);

    // Clear counters, then stall 17 cycles: stall and issue stick at 15.
    step(0, 0, 0, 0, 1, 32'h204, I7, 32'h0, 32'h204, I7, 1, 32'h0, 0, 0, 0, 0);
    for (int k = 1; k <= 17; k++)
      step(1, 1, 0, 0, 0, 32'h208, I8, T8, 32'h204, I7, 1, T8, 1,
           (k > 15) ? 15 : k, 0, (k > 15) ? 15 : k);
    // Clear wins over the stall increment in the same cycle.
    step(1, 1, 0, 0, 1, 32'h208, I8, T8,    32'h204, I7, 1, T8,    1, 0, 0, 0);

    // Mid-stream asynchronous reset between edges, then fetch resumes at 0.
    step(0, 0, 0, 0, 0, 32'h300, I9, T9,    32'h300, I9, 1, T9,    1, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    expectReset();
    #2;
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 32'h4,   I0, 32'h0, 32'h4,   I0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h8,   I1, T1,    32'h8,   I1, 1, T1,    1, 0, 0, 1);

    @(posedge clk);
    #3;
    nCmp++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
